// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and bit-rate constants
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam int UART_BIT_CYCLES_50M = 217;
   localparam int UART_BIT_CYCLES_75M = 325;
endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: CPU-side push bus and status of the buffered transmitter
interface uart_tx_buffered_if #(parameter int FIFO_AW = 2);
   logic wr;
   logic [7:0] wr_data;
   logic full;
   logic [FIFO_AW:0] level;
   logic busy;
   logic overflow;
   logic ovf_clr;
   modport master (output wr, wr_data, ovf_clr, input full, level, busy, overflow);
   modport slave (input wr, wr_data, ovf_clr, output full, level, busy, overflow);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead synchronous FIFO with registered occupancy
module uart_sync_fifo #(
   parameter int W = 8,
   parameter int AW = 2
) (
   input logic sclk,
   input logic reset,
   input logic push,
   input logic pop,
   input logic [W-1:0] din,
   output logic [W-1:0] rd_data,
   output logic full,
   output logic empty,
   output logic [AW:0] level
);
   logic [W-1:0] mem [2**AW];
   logic [AW-1:0] wptr, rptr;
   logic do_push, do_pop;
   assign full = level[AW];
   assign empty = level == '0;
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign rd_data = mem[rptr];
   always_ff @(posedge sclk or negedge reset)
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         level <= '0;
      end else begin
         wptr <= wptr + AW'(do_push);
         rptr <= rptr + AW'(do_pop);
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge sclk)
      if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fed 8N1 serialiser, frames sent back-to-back LSB first
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int BIT_CYCLES = UART_BIT_CYCLES_50M,
   parameter int FIFO_AW = 2,
   parameter int STOP_BITS = 1
) (
   input logic sclk,
   input logic reset,
   uart_tx_buffered_if.slave bus,
   output logic dout
);
   localparam int TW = $clog2(BIT_CYCLES);
   tx_state_t state, state_nxt;
   logic [TW-1:0] tmr;
   logic [7:0] shreg, head;
   logic [2:0] idx;
   logic empty, pop, expired, last_stop;
   assign expired = tmr == '0;
   assign last_stop = idx == 3'(STOP_BITS - 1);
   uart_sync_fifo #(.W(8), .AW(FIFO_AW)) fifo (
      .sclk(sclk),
      .reset(reset),
      .push(bus.wr),
      .pop(pop),
      .din(bus.wr_data),
      .rd_data(head),
      .full(bus.full),
      .empty(empty),
      .level(bus.level)
   );
   always_ff @(posedge sclk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!empty) state_nxt = START;
         START: if (expired) state_nxt = DATA;
         DATA: if (expired && idx == 3'd7) state_nxt = STOP;
         STOP: if (expired && last_stop) state_nxt = empty ? IDLE : START;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      pop = ~empty & (state == IDLE | (state == STOP & expired & last_stop));
      dout = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
      bus.busy = state != IDLE | ~empty;
   end
   // idx counts data bits in DATA and stop bits in STOP; a pop restarts it
   always_ff @(posedge sclk or negedge reset)
      if (!reset) begin
         tmr <= '0;
         shreg <= '0;
         idx <= '0;
         bus.overflow <= 1'b0;
      end else begin
         tmr <= pop ? TW'(BIT_CYCLES - 1) : state == IDLE ? '0 : expired ? TW'(BIT_CYCLES - 1) : tmr - 1'b1;
         shreg <= pop ? head : (state == DATA && expired) ? shreg >> 1 : shreg;
         idx <= pop ? '0 : (expired && state inside {DATA, STOP}) ? idx + 1'b1 : idx;
         bus.overflow <= (bus.wr & bus.full) | (bus.overflow & ~bus.ovf_clr);
      end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of framing, queuing, overflow and reset abort
module tb_uart_tx_buffered;
   logic sclk, reset, dout1, dout2;
   int errors = 0;
   int checks = 0;
   uart_tx_buffered_if #(.FIFO_AW(2)) b1 ();
   uart_tx_buffered_if #(.FIFO_AW(2)) b2 ();
   uart_tx_buffered #(.BIT_CYCLES(4), .FIFO_AW(2), .STOP_BITS(1)) dut1 (
      .sclk(sclk), .reset(reset), .bus(b1.slave), .dout(dout1));
   uart_tx_buffered #(.BIT_CYCLES(4), .FIFO_AW(2), .STOP_BITS(2)) dut2 (
      .sclk(sclk), .reset(reset), .bus(b2.slave), .dout(dout2));
   initial begin
      sclk = 0;
      forever #5 sclk = ~sclk;
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   // Samples dout once per cycle from frame sample index 'first' (now) to the frame end
   task automatic watch_frame(input logic [7:0] b, input int stops, input int sel, input int first, input string name);
      int bad = 0;
      logic exp, got;
      for (int j = first; j < (9 + stops) * 4; j++) begin
         if (j != first) @(negedge sclk);
         exp = (j < 4) ? 1'b0 : (j < 36) ? b[(j - 4) / 4] : 1'b1;
         got = sel ? dout2 : dout1;
         if (got !== exp && bad == 0) begin
            $display("FAIL %s sample %0d dout=%b expected %b", name, j, got, exp);
            bad = 1;
         end
      end
      checks++;
      errors += bad;
   endtask
   task automatic test_reset;
      reset = 0;
      b1.wr = 0; b1.wr_data = 0; b1.ovf_clr = 0;
      b2.wr = 0; b2.wr_data = 0; b2.ovf_clr = 0;
      repeat (2) @(negedge sclk);
      checks++; if (dout1 !== 1'b1) begin errors++; $display("FAIL rst_dout got=%b exp=1", dout1); end
      checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", b1.busy); end
      checks++; if (b1.level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", b1.level); end
      checks++; if (b1.full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", b1.full); end
      checks++; if (b1.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", b1.overflow); end
      checks++; if (dout2 !== 1'b1) begin errors++; $display("FAIL rst_dout2 got=%b exp=1", dout2); end
      reset = 1;
      @(negedge sclk);
   endtask
   task automatic test_single;
      b1.wr = 1; b1.wr_data = 8'hA5;
      @(posedge sclk); @(negedge sclk);
      b1.wr = 0;
      checks++; if (b1.level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", b1.level); end
      checks++; if (dout1 !== 1'b1) begin errors++; $display("FAIL single_pre_dout got=%b exp=1", dout1); end
      checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", b1.busy); end
      @(negedge sclk);
      watch_frame(8'hA5, 1, 0, 0, "frame_a5");
      @(negedge sclk);
      checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", b1.busy); end
      checks++; if (dout1 !== 1'b1) begin errors++; $display("FAIL single_idle_dout got=%b exp=1", dout1); end
   endtask
   task automatic test_back_to_back;
      b1.wr = 1; b1.wr_data = 8'h00;
      @(posedge sclk); @(negedge sclk);
      b1.wr_data = 8'hFF;
      @(posedge sclk); @(negedge sclk);
      b1.wr_data = 8'h55;
      @(posedge sclk); @(negedge sclk);
      b1.wr = 0;
      checks++; if (b1.level !== 3'd2) begin errors++; $display("FAIL b2b_level2 got=%0d exp=2", b1.level); end
      watch_frame(8'h00, 1, 0, 1, "frame_00");
      @(negedge sclk);
      checks++; if (b1.level !== 3'd1) begin errors++; $display("FAIL b2b_level1 got=%0d exp=1", b1.level); end
      watch_frame(8'hFF, 1, 0, 0, "frame_ff");
      @(negedge sclk);
      checks++; if (b1.level !== 3'd0) begin errors++; $display("FAIL b2b_level0 got=%0d exp=0", b1.level); end
      watch_frame(8'h55, 1, 0, 0, "frame_55");
      @(negedge sclk);
      checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b exp=0", b1.busy); end
   endtask
   task automatic test_overflow;
      logic [7:0] d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 6; i++) begin
         b1.wr = 1; b1.wr_data = d[i];
         if (i == 5) b1.ovf_clr = 1;
         @(posedge sclk); @(negedge sclk);
      end
      b1.wr = 0;
      checks++; if (b1.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", b1.overflow); end
      checks++; if (b1.full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", b1.full); end
      checks++; if (b1.level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", b1.level); end
      fork
         begin @(posedge sclk); #1 b1.ovf_clr = 0; end
      join_none
      watch_frame(d[0], 1, 0, 4, "frame_11");
      checks++; if (b1.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", b1.overflow); end
      checks++; if (b1.level !== 3'd4) begin errors++; $display("FAIL ovf_level_hold got=%0d exp=4", b1.level); end
      for (int i = 1; i < 5; i++) begin
         @(negedge sclk);
         watch_frame(d[i], 1, 0, 0, $sformatf("frame_ovf%0d", i));
      end
      @(negedge sclk);
      checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL ovf_drop_busy got=%b exp=0", b1.busy); end
      checks++; if (b1.level !== 3'd0) begin errors++; $display("FAIL ovf_drop_level got=%0d exp=0", b1.level); end
   endtask
   task automatic test_reset_mid_frame;
      b1.wr = 1; b1.wr_data = 8'hF0;
      @(posedge sclk); @(negedge sclk);
      b1.wr_data = 8'hAA;
      @(posedge sclk); @(negedge sclk);
      b1.wr = 0;
      repeat (17) @(negedge sclk);
      checks++; if (dout1 !== 1'b0) begin errors++; $display("FAIL mid_bit3 got=%b exp=0", dout1); end
      checks++; if (b1.level !== 3'd1) begin errors++; $display("FAIL mid_level got=%0d exp=1", b1.level); end
      reset = 0;
      #1;
      checks++; if (dout1 !== 1'b1) begin errors++; $display("FAIL abort_dout got=%b exp=1", dout1); end
      checks++; if (b1.level !== 3'd0) begin errors++; $display("FAIL abort_level got=%0d exp=0", b1.level); end
      checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", b1.busy); end
      @(negedge sclk);
      reset = 1;
      @(negedge sclk);
      b1.wr = 1; b1.wr_data = 8'h3C;
      @(posedge sclk); @(negedge sclk);
      b1.wr = 0;
      @(negedge sclk);
      watch_frame(8'h3C, 1, 0, 0, "frame_3c");
      @(negedge sclk);
      checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", b1.busy); end
   endtask
   task automatic test_two_stop;
      b2.wr = 1; b2.wr_data = 8'h81;
      @(posedge sclk); @(negedge sclk);
      b2.wr_data = 8'h7E;
      @(posedge sclk); @(negedge sclk);
      b2.wr = 0;
      checks++; if (b2.level !== 3'd1) begin errors++; $display("FAIL stop2_level got=%0d exp=1", b2.level); end
      watch_frame(8'h81, 2, 1, 0, "frame2_81");
      @(negedge sclk);
      watch_frame(8'h7E, 2, 1, 0, "frame2_7e");
      @(negedge sclk);
      checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL stop2_busy got=%b exp=0", b2.busy); end
      checks++; if (dout2 !== 1'b1) begin errors++; $display("FAIL stop2_idle got=%b exp=1", dout2); end
   endtask
   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_overflow;
      test_reset_mid_frame;
      test_two_stop;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
